// File: rtl/fifo_wr_arbiter_if.sv
// Bundle between the write arbiter, its requesters and the downstream FIFO.
// Also carries read-only debug views of the arbiter's internal state.
interface fifo_wr_arbiter_if #(
    parameter int DATA_WIDTH = 8,
    parameter int REQ_NUM    = 4,
    parameter int BURST_LEN  = 4
);
    localparam int CNT_W = $clog2(BURST_LEN + 1);
    localparam int IDX_W = $clog2(REQ_NUM);

    // Handshake: requester k's word moves on a rising edge where
    // valid_i[k] && ready_o[k]; that same edge has fifo_wr_en_o = 1.
    // A requester holds its word stable until it is accepted.
    logic [REQ_NUM-1:0]            valid_i;
    logic [REQ_NUM*DATA_WIDTH-1:0] data_i;
    logic [REQ_NUM-1:0]            ready_o;
    logic                          fifo_wr_en_o;
    logic [DATA_WIDTH-1:0]         fifo_wr_data_o;
    logic                          fifo_full_i;
    logic [REQ_NUM-1:0]            grant_o;
    logic                          busy_o;
    logic                          dbg_state_o;
    logic [CNT_W-1:0]              dbg_burst_cnt_o;
    logic [IDX_W-1:0]              dbg_last_grant_o;

    modport slave (
        input  valid_i, data_i, fifo_full_i,
        output ready_o, fifo_wr_en_o, fifo_wr_data_o, grant_o, busy_o,
               dbg_state_o, dbg_burst_cnt_o, dbg_last_grant_o
    );

    modport master (
        output valid_i, data_i, fifo_full_i,
        input  ready_o, fifo_wr_en_o, fifo_wr_data_o, grant_o, busy_o,
               dbg_state_o, dbg_burst_cnt_o, dbg_last_grant_o
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter granting one requester at a time a burst of up to
// BURST_LEN writes into a shared FIFO, with a mandatory idle cycle between grants.
module fifo_wr_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int REQ_NUM    = 4,
    parameter int BURST_LEN  = 4
) (
    input logic              clk_i,
    input logic              a_rst_n_i,
    fifo_wr_arbiter_if.slave bus
);
    localparam int CNT_W = $clog2(BURST_LEN + 1);
    localparam int IDX_W = $clog2(REQ_NUM);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [REQ_NUM-1:0] grant_q, grant_d;
    logic [IDX_W-1:0]   gidx_q, gidx_d;
    logic [IDX_W-1:0]   last_q, last_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               pick_found;
    logic [IDX_W-1:0]   pick_idx;
    logic [REQ_NUM-1:0] ready;
    logic               wr_en;
    logic [DATA_WIDTH-1:0] wr_data;
    logic               g_valid;

    // Search starts one past the last granted index and wraps.
    always_comb begin
        int j;
        j          = 0;
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int i = 1; i <= REQ_NUM; i++) begin
            j = (int'(last_q) + i) % REQ_NUM;
            if (!pick_found && bus.valid_i[j]) begin
                pick_found = 1'b1;
                pick_idx   = IDX_W'(j);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        gidx_d  = gidx_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        ready   = '0;
        wr_en   = 1'b0;
        wr_data = '0;
        g_valid = bus.valid_i[gidx_q];
        case (state_q)
            IDLE: begin
                if (pick_found && !bus.fifo_full_i) begin
                    state_d = GRANT;
                    gidx_d  = pick_idx;
                    grant_d = {{(REQ_NUM-1){1'b0}}, 1'b1} << pick_idx;
                    cnt_d   = '0;
                end
            end
            GRANT: begin
                ready[gidx_q] = !bus.fifo_full_i;
                wr_en         = g_valid && !bus.fifo_full_i;
                wr_data       = bus.data_i[int'(gidx_q)*DATA_WIDTH +: DATA_WIDTH];
                if (wr_en) begin
                    cnt_d = cnt_q + 1'b1;
                end
                // A full FIFO with valid data stalls; only a drop or the last beat releases.
                if (!g_valid || (wr_en && cnt_q == CNT_W'(BURST_LEN - 1))) begin
                    state_d = IDLE;
                    grant_d = '0;
                    last_d  = gidx_q;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge a_rst_n_i) begin
        if (!a_rst_n_i) begin
            state_q <= IDLE;
            grant_q <= '0;
            gidx_q  <= '0;
            last_q  <= IDX_W'(REQ_NUM - 1);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            gidx_q  <= gidx_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.ready_o          = ready;
    assign bus.fifo_wr_en_o     = wr_en;
    assign bus.fifo_wr_data_o   = wr_data;
    assign bus.grant_o          = grant_q;
    assign bus.busy_o           = (state_q == GRANT);
    assign bus.dbg_state_o      = state_q;
    assign bus.dbg_burst_cnt_o  = cnt_q;
    assign bus.dbg_last_grant_o = last_q;
endmodule
